// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer between the pipeline and a single-port data RAM
// with variable latency; stalls the pipeline and aborts accesses that wait too long.
module mem_access_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ram_read_mem,
   input  logic                  ram_write_mem,
   input  logic [2:0]            funct3_mem,
   input  logic [DATA_WIDTH-1:0] alu_result_mem,
   input  logic [DATA_WIDTH-1:0] store_data_mem,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_wstrb,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   input  logic                  dmem_ready,
   output logic [DATA_WIDTH-1:0] ram_out_mem,
   output logic                  mem_stall,
   output logic                  mem_err
);

   typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

   localparam logic [8:0] TIMEOUT_LIM_C = 9'(TIMEOUT_CYCLES);

   state_t      state_r, state_nxt_s;
   logic [7:0]  cnt_r;
   logic [8:0]  cnt_inc_s;
   logic        err_r;
   logic [2:0]  ld_f3_r;
   logic [1:0]  ld_off_r;
   logic        is_load_r;
   logic        access_s, illegal_s, misalign_s;
   logic        launch_s, complete_s, abort_s;

   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   store_wdata = {4{d[7:0]}};
         2'b01:   store_wdata = {2{d[15:0]}};
         default: store_wdata = d;
      endcase
   endfunction

   function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   store_wstrb = 4'b0001 << off;
         2'b01:   store_wstrb = off[1] ? 4'b1100 : 4'b0011;
         default: store_wstrb = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
      logic [31:0] sh_v;
      logic [15:0] half_v;
      sh_v   = w >> {off, 3'b000};
      half_v = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_extract = {{24{sh_v[7]}}, sh_v[7:0]};
         3'b100:  load_extract = {24'd0, sh_v[7:0]};
         3'b001:  load_extract = {{16{half_v[15]}}, half_v};
         3'b101:  load_extract = {16'd0, half_v};
         3'b010:  load_extract = w;
         default: load_extract = 32'd0;
      endcase
   endfunction

   // Access decode: legality and alignment of the MEM-stage request
   always_comb begin
      access_s   = ram_read_mem | ram_write_mem;
      cnt_inc_s  = {1'b0, cnt_r} + 9'd1;
      illegal_s  = 1'b0;
      misalign_s = 1'b0;
      case (funct3_mem)
         3'b011, 3'b110, 3'b111: illegal_s  = 1'b1;
         3'b001, 3'b101:         misalign_s = alu_result_mem[0];
         3'b010:                 misalign_s = (alu_result_mem[1:0] != 2'b00);
         default:                misalign_s = 1'b0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state, stall and error decode
   always_comb begin
      state_nxt_s = state_r;
      launch_s    = 1'b0;
      complete_s  = 1'b0;
      abort_s     = 1'b0;
      mem_stall   = 1'b0;
      mem_err     = 1'b0;
      if (rst) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (access_s) begin
                  if (illegal_s || misalign_s) begin
                     mem_err = 1'b1;
                  end else begin
                     launch_s    = 1'b1;
                     mem_stall   = 1'b1;
                     state_nxt_s = BUSY;
                  end
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            BUSY: begin
               mem_stall = 1'b1;
               if (dmem_ready) begin
                  complete_s  = 1'b1;
                  state_nxt_s = DONE;
               end else if (cnt_inc_s >= TIMEOUT_LIM_C) begin
                  abort_s     = 1'b1;
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = BUSY;
               end
            end
            DONE: begin
               mem_err     = err_r;
               state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // RAM request fields, load result, timeout counter and abort flag
   always_ff @(posedge clk) begin
      if (rst) begin
         dmem_req    <= 1'b0;
         dmem_we     <= 1'b0;
         dmem_addr   <= {DATA_WIDTH{1'b0}};
         dmem_wstrb  <= 4'b0000;
         dmem_wdata  <= {DATA_WIDTH{1'b0}};
         ram_out_mem <= {DATA_WIDTH{1'b0}};
         cnt_r       <= 8'd0;
         err_r       <= 1'b0;
         ld_f3_r     <= 3'b000;
         ld_off_r    <= 2'b00;
         is_load_r   <= 1'b0;
      end else if (launch_s) begin
         dmem_req   <= 1'b1;
         dmem_we    <= ram_write_mem;
         dmem_addr  <= {alu_result_mem[DATA_WIDTH-1:2], 2'b00};
         dmem_wstrb <= ram_write_mem ? store_wstrb(funct3_mem, alu_result_mem[1:0]) : 4'b0000;
         dmem_wdata <= ram_write_mem ? store_wdata(funct3_mem, store_data_mem)
                                     : {DATA_WIDTH{1'b0}};
         ld_f3_r    <= funct3_mem;
         ld_off_r   <= alu_result_mem[1:0];
         is_load_r  <= ~ram_write_mem;
         cnt_r      <= 8'd0;
         err_r      <= 1'b0;
      end else if (complete_s) begin
         dmem_req <= 1'b0;
         if (is_load_r) begin
            ram_out_mem <= load_extract(ld_f3_r, ld_off_r, dmem_rdata);
         end else begin
            ram_out_mem <= ram_out_mem;
         end
      end else if (abort_s) begin
         dmem_req <= 1'b0;
         err_r    <= 1'b1;
         if (is_load_r) begin
            ram_out_mem <= {DATA_WIDTH{1'b0}};
         end else begin
            ram_out_mem <= ram_out_mem;
         end
      end else if (state_r == BUSY) begin
         cnt_r <= cnt_inc_s[7:0];
      end else begin
         err_r <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases followed by
// randomized loads/stores compared against an arithmetic reference model.
module tb_mem_access_unit;

   localparam int TO_C = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ram_read_mem, ram_write_mem;
   logic [2:0]  funct3_mem;
   logic [31:0] alu_result_mem, store_data_mem;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, ram_out_mem;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready, mem_stall, mem_err;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_ram_out = 32'd0;

   mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO_C)) dut (
      .clk(clk), .rst(rst),
      .ram_read_mem(ram_read_mem), .ram_write_mem(ram_write_mem),
      .funct3_mem(funct3_mem), .alu_result_mem(alu_result_mem),
      .store_data_mem(store_data_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .ram_out_mem(ram_out_mem), .mem_stall(mem_stall), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ram_read_mem   = 1'b0;
      ram_write_mem  = 1'b0;
      funct3_mem     = 3'b000;
      alu_result_mem = 32'd0;
      store_data_mem = 32'd0;
   endtask

   // One MEM-stage instruction, held until the pipeline would advance.
   task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input int waits, input logic [31:0] rdat);
      int          sz, off, n;
      logic        bad, timed_out, is_st;
      logic [31:0] e_wd, e_ld, v;
      logic [3:0]  e_ws;
      sz    = int'(f3[1:0]);
      off   = int'(addr[1:0]);
      is_st = wr;
      bad   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (sz == 1 && addr[0]) || (sz == 2 && off != 0);
      // expected store lanes
      if (sz == 0) begin
         e_wd = (sd & 32'hFF) * 32'h01010101;
         e_ws = 4'(1 << off);
      end else if (sz == 1) begin
         e_wd = (sd & 32'hFFFF) * 32'h00010001;
         e_ws = (off >= 2) ? 4'hC : 4'h3;
      end else begin
         e_wd = sd;
         e_ws = 4'hF;
      end
      // expected load value
      if (sz == 0) begin
         v = (rdat >> (8 * off)) & 32'hFF;
         e_ld = (!f3[2] && v >= 32'd128) ? (v | 32'hFFFFFF00) : v;
      end else if (sz == 1) begin
         v = (rdat >> (16 * (off / 2))) & 32'hFFFF;
         e_ld = (!f3[2] && v >= 32'h8000) ? (v | 32'hFFFF0000) : v;
      end else begin
         e_ld = rdat;
      end

      ram_read_mem   = rd;
      ram_write_mem  = wr;
      funct3_mem     = f3;
      alu_result_mem = addr;
      store_data_mem = sd;
      @(negedge clk);

      if (!(rd | wr)) begin
         check_val("nop_stall", mem_stall, 1'b0);
         check_val("nop_err", mem_err, 1'b0);
         step();
         check_val("nop_req", dmem_req, 1'b0);
      end else if (bad) begin
         check_val("bad_err", mem_err, 1'b1);
         check_val("bad_stall", mem_stall, 1'b0);
         step();
         clear_inputs();
         @(negedge clk);
         check_val("bad_req", dmem_req, 1'b0);
         check_val("bad_err_gone", mem_err, 1'b0);
         check_val("bad_ram_out", ram_out_mem, exp_ram_out);
      end else begin
         check_val("idle_stall", mem_stall, 1'b1);
         check_val("idle_err", mem_err, 1'b0);
         timed_out = (waits >= TO_C);
         n = timed_out ? TO_C : waits + 1;
         step();
         for (int k = 0; k < n; k++) begin
            dmem_ready = (!timed_out && k == waits);
            dmem_rdata = (!timed_out && k == waits) ? rdat : $urandom;
            @(negedge clk);
            check_val("busy_req", dmem_req, 1'b1);
            check_val("busy_stall", mem_stall, 1'b1);
            check_val("busy_we", dmem_we, is_st);
            check_val("busy_addr", dmem_addr, addr & 32'hFFFFFFFC);
            check_val("busy_wstrb", dmem_wstrb, is_st ? e_ws : 4'h0);
            if (is_st) check_val("busy_wdata", dmem_wdata, e_wd);
            step();
         end
         dmem_ready = 1'b0;
         if (!is_st) exp_ram_out = timed_out ? 32'd0 : e_ld;
         @(negedge clk);
         check_val("done_stall", mem_stall, 1'b0);
         check_val("done_req", dmem_req, 1'b0);
         check_val("done_err", mem_err, timed_out);
         check_val("done_ram_out", ram_out_mem, exp_ram_out);
         step();
         clear_inputs();
         @(negedge clk);
         check_val("post_stall", mem_stall, 1'b0);
         check_val("post_err", mem_err, 1'b0);
      end
      clear_inputs();
      step();
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          kind;
      rst        = 1'b1;
      dmem_ready = 1'b0;
      dmem_rdata = 32'd0;
      clear_inputs();
      repeat (2) step();
      // access present while in reset: no stall, no error
      ram_read_mem   = 1'b1;
      funct3_mem     = 3'b011;
      alu_result_mem = 32'h0000_0101;
      @(negedge clk);
      check_val("rst_stall", mem_stall, 1'b0);
      check_val("rst_err", mem_err, 1'b0);
      check_val("rst_req", dmem_req, 1'b0);
      check_val("rst_we", dmem_we, 1'b0);
      check_val("rst_addr", dmem_addr, 32'd0);
      check_val("rst_wstrb", dmem_wstrb, 4'h0);
      check_val("rst_wdata", dmem_wdata, 32'd0);
      check_val("rst_ram_out", ram_out_mem, 32'd0);
      step();
      rst = 1'b0;
      clear_inputs();
      step();

      // directed scenarios
      run_txn(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 2, 32'h8011_2233);
      check_val("lb_result", ram_out_mem, 32'hFFFF_FF80);
      run_txn(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 0, 32'd0);
      check_val("sh_keeps_out", ram_out_mem, 32'hFFFF_FF80);
      run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 32'd0);
      run_txn(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'd0, 10, 32'd0);
      check_val("timeout_out", ram_out_mem, 32'd0);
      run_txn(1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h1234_5678, 1, 32'd0);
      run_txn(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 0, 32'hDEAD_BEEF);
      check_val("lw_result", ram_out_mem, 32'hDEAD_BEEF);

      // reset in the middle of BUSY, then a late ready
      ram_read_mem   = 1'b1;
      funct3_mem     = 3'b010;
      alu_result_mem = 32'h0000_0020;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      clear_inputs();
      dmem_ready = 1'b1;
      dmem_rdata = 32'h0000_1234;
      @(negedge clk);
      check_val("rstb_req", dmem_req, 1'b0);
      check_val("rstb_stall", mem_stall, 1'b0);
      check_val("rstb_out", ram_out_mem, 32'd0);
      step();
      dmem_ready = 1'b0;
      @(negedge clk);
      check_val("rstb_late_req", dmem_req, 1'b0);
      check_val("rstb_late_out", ram_out_mem, 32'd0);
      exp_ram_out = 32'd0;
      step();

      // randomized traffic
      for (int t = 0; t < 150; t++) begin
         kind = int'($urandom_range(0, 3));
         f3   = 3'($urandom_range(0, 7));
         a    = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            a = (f3[1:0] == 2'b10) ? (a & 32'hFFFF_FFFC) :
                (f3[1:0] == 2'b01) ? (a & 32'hFFFF_FFFE) : a;
         end
         run_txn(kind == 0 || kind == 2, kind == 1 || kind == 2, f3, a, $urandom,
                 int'($urandom_range(0, 5)), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the data and address width; only 32 is supported.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of BUSY cycles before abort (range 1-255, 8-bit counter).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ram_read_mem  input  1  current MEM-stage instruction is a load.
REQ-007 ram_write_mem  input  1  current MEM-stage instruction is a store.
REQ-008 funct3_mem  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 alu_result_mem  input  32  byte address of the access.
REQ-010 store_data_mem  input  32  store data (rs2 value), size-aligned in the low bits.
REQ-011 dmem_req  output  1  data-RAM request, registered.
REQ-012 dmem_we  output  1  1 = write, 0 = read; registered.
REQ-013 dmem_addr  output  32  word address {addr[31:2],2'b00}; registered.
REQ-014 dmem_wstrb  output  4  byte-lane write strobes; registered; 0000 for reads.
REQ-015 dmem_wdata  output  32  lane-replicated store data; registered.
REQ-016 dmem_rdata  input  32  read data, valid when dmem_ready=1.
REQ-017 dmem_ready  input  1  RAM completion, sampled only in BUSY.
REQ-018 ram_out_mem  output  32  aligned, extended load result, registered, consumed by the MEM/WB register.
REQ-019 mem_stall  output  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while high.
REQ-020 mem_err  output  1  one-cycle pulse: misaligned, illegal-funct3 or timed-out access.

Function
REQ-021 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-022 IDLE: access = ram_read_mem|ram_write_mem; when both are high, the store wins and the read is ignored.
REQ-023 Illegal = funct3 in {011,110,111}; misaligned = H/HU with addr[0]=1 or W with addr[1:0]!=00.
REQ-024 IDLE, legal aligned access: register the dmem_* fields, set dmem_req=1, go BUSY.
REQ-025 IDLE, illegal or misaligned access: no request, stay IDLE, mem_err=1 combinationally that cycle, ram_out_mem unchanged.
REQ-026 Store lanes SHALL be: SB wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=addr[1]?1100:0011; SW wdata=d, wstrb=1111.
REQ-027 BUSY: dmem_req, dmem_we, dmem_addr, dmem_wstrb and dmem_wdata SHALL hold stable until dmem_ready=1.
REQ-028 BUSY with dmem_ready=1: for a load, capture the extracted value into ram_out_mem; clear dmem_req; go DONE.
REQ-029 Load extraction SHALL be: B/BU lane addr[1:0] sign/zero-extended; H/HU lane addr[1] sign/zero-extended; W whole word.
REQ-030 The timeout counter SHALL clear on BUSY entry and increment on each BUSY cycle without ready.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES: clear dmem_req, set ram_out_mem=0 for loads, pulse mem_err registered in DONE, go DONE.
REQ-032 DONE SHALL return to IDLE unconditionally after one cycle; new inputs are not evaluated in DONE.
REQ-033 mem_stall SHALL be 1 in BUSY, and 1 in IDLE when a legal aligned access is present; it SHALL be 0 in DONE and otherwise.
REQ-034 Minimum latency SHALL be 3 cycles (IDLE, BUSY with ready, DONE); the pipeline advances at the end of DONE.
REQ-035 Stores SHALL NOT modify ram_out_mem.

Reset
REQ-036 With rst=1 at a clock edge: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wstrb=0, dmem_wdata=0, ram_out_mem=0, timeout counter=0, registered mem_err=0.
REQ-037 Reset mid-BUSY SHALL drop dmem_req on the next edge; a late dmem_ready is then ignored.
REQ-038 mem_stall and combinational mem_err SHALL be 0 while rst=1.

Verification
REQ-039 LB at addr 0x103, rdata=0x80112233 after 2 wait cycles -> stall for 4 cycles, ram_out_mem=0xFFFFFF80.
REQ-040 SH at 0x202, data 0x0000ABCD -> dmem_addr=0x200, wstrb=1100, wdata=0xABCDABCD, dmem_we=1, ram_out_mem unchanged.
REQ-041 LW at 0x101 -> no dmem_req, mem_err for 1 cycle, mem_stall=0.
REQ-042 LHU at 0x000, ready never asserted, TIMEOUT_CYCLES=4 -> dmem_req drops after 4 BUSY cycles, mem_err in DONE, ram_out_mem=0.
REQ-043 Read and write both high, SW at 0x40 -> write performed with wstrb=1111.
REQ-044 rst asserted during BUSY, then dmem_ready=1 -> dmem_req=0, state IDLE, ram_out_mem=0.
